// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle core: word widths, instruction
// field bounds, the NOP encoding and the packed fetch-queue entry.
package cpu_pkg;

  localparam int INS_W = 32;
  localparam int PC_W  = 32;

  // Instruction field bounds
  localparam int OPC_HI   = 31;
  localparam int OPC_LO   = 28;
  localparam int FUNCT_HI = 27;
  localparam int FUNCT_LO = 24;
  localparam int RS1_HI   = 23;
  localparam int RS1_LO   = 20;
  localparam int RS2_HI   = 19;
  localparam int RS2_LO   = 16;
  localparam int RD_HI    = 15;
  localparam int RD_LO    = 12;

  localparam logic [INS_W-1:0] NOP_INS = 32'h0000_0000;

  // One queued fetch: the address the word came from and the word itself.
  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic [INS_W-1:0] ins;
  } fetch_entry_t;

  localparam int ENTRY_W = PC_W + INS_W;

  function automatic logic [OPC_HI-OPC_LO:0] opcode_of(input logic [INS_W-1:0] ins);
    return ins[OPC_HI:OPC_LO];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small circular buffer for fetched instructions. Registered storage with a
// combinational head read; flush empties it and wins over push and pop.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int W     = 64,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [CW-1:0] count,
  output logic [W-1:0]  head,
  output logic          empty
);

  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          full;
  logic          push_ok;
  logic          pop_ok;

  assign empty = (count == '0);
  assign full  = (count == CNT_DEPTH);
  assign head  = mem[rd_ptr];

  // A pop frees a slot in the same cycle, so a push into a full buffer is
  // still accepted when it coincides with a pop.
  always_comb begin
    pop_ok  = pop && !empty;
    push_ok = push && (!full || pop_ok);
  end

  // Entry storage; no reset needed since reads are qualified by count.
  always_ff @(posedge clk) begin
    if (push_ok && !flush && !reset) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally modulo DEPTH.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch stage: issues sequential reads to a 1-cycle synchronous
// instruction memory, queues the returned words with their PC, and hands
// them to the core. A redirect discards everything and restarts fetch.
//
// Handshake (core side): an entry transfers on a rising edge where
// out_valid && out_ready are both high. out_valid never depends on
// out_ready, and while out_valid && !out_ready the out_* values hold still.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [PC_W-1:0] PC_STEP  = 32'd4
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_en,
  output logic [PC_W-1:0]  imem_addr,
  input  logic [INS_W-1:0] imem_data,
  input  logic             redirect,
  input  logic [PC_W-1:0]  redirect_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [INS_W-1:0] out_ins,
  output logic [PC_W-1:0]  out_pc,
  output logic [PC_W-1:0]  out_pcinc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] CREDITS = (CW + 1)'(DEPTH);

  logic [PC_W-1:0] fetch_pc;
  logic            inflight;
  logic [PC_W-1:0] inflight_pc;

  logic [CW-1:0]   count;
  logic [CW:0]     credit_used;
  logic            fifo_empty;
  logic            push;
  logic            pop;
  fetch_entry_t    push_entry;
  fetch_entry_t    head_entry;
  logic [ENTRY_W-1:0] head_bits;

  // Issue only when every queued and outstanding word still has a slot. The
  // registered count is used, so a same-cycle pop does not earn a credit.
  always_comb begin
    credit_used = {1'b0, count} + {{CW{1'b0}}, inflight};
    imem_en     = !reset && !redirect && (credit_used < CREDITS);
    imem_addr   = fetch_pc;
  end

  // Fetch address and outstanding-request tracking; redirect overrides issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect) begin
      fetch_pc    <= redirect_pc;
      inflight    <= 1'b0;
    end else if (imem_en) begin
      fetch_pc    <= fetch_pc + PC_STEP;
      inflight    <= 1'b1;
      inflight_pc <= fetch_pc;
    end else begin
      inflight    <= 1'b0;
    end
  end

  // The response to last cycle's request is queued unless a redirect is
  // flushing in this same cycle, in which case it is stale and dropped.
  always_comb begin
    push_entry.pc  = inflight_pc;
    push_entry.ins = imem_data;
    push           = inflight && !redirect;
    pop            = out_valid && out_ready;
  end

  fetch_fifo #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .count     (count),
    .head      (head_bits),
    .empty     (fifo_empty)
  );

  // Head presentation; outputs read as zero whenever the queue is empty so
  // nothing stale from storage leaks out after reset or a flush.
  always_comb begin
    head_entry = fetch_entry_t'(head_bits);
    out_valid  = !fifo_empty;
    out_ins    = NOP_INS;
    out_pc     = '0;
    out_pcinc  = '0;
    if (out_valid) begin
      out_ins   = head_entry.ins;
      out_pc    = head_entry.pc;
      out_pcinc = head_entry.pc + PC_STEP;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a synchronous memory model returning
// a recognisable word per address, a scoreboard fed from issued reads, and
// one task per scenario with its own inline checks.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_data = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_ins;
  logic [31:0] out_pc;
  logic [31:0] out_pcinc;

  int checks = 0;
  int failures = 0;

  logic [63:0] exp_q[$];
  logic [63:0] sb_exp;

  fetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0000_0000),
    .PC_STEP  (32'd4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_en     (imem_en),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_ins     (out_ins),
    .out_pc      (out_pc),
    .out_pcinc   (out_pcinc)
  );

  // Clock
  always #5 clk = ~clk;

  // Word stored at address a: tagged with the word index a/4.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hC000_0000 | (a >> 2);
  endfunction

  // Synchronous instruction memory, one cycle read latency.
  always @(posedge clk) begin
    if (imem_en) imem_data <= mem_word(imem_addr);
  end

  // Scoreboard: every issued read is expected at the head later, in order.
  always @(negedge clk) begin
    if (reset || redirect) begin
      exp_q.delete();
    end else begin
      if (out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected: got pc=%h ins=%h, expected no entry", out_pc, out_ins);
        end else begin
          sb_exp = exp_q[0];
          if (out_pc !== sb_exp[63:32] || out_ins !== sb_exp[31:0] ||
              out_pcinc !== sb_exp[63:32] + 32'd4) begin
            failures++;
            $display("FAIL sb_head: got pc=%h ins=%h pcinc=%h, expected pc=%h ins=%h pcinc=%h",
                     out_pc, out_ins, out_pcinc, sb_exp[63:32], sb_exp[31:0], sb_exp[63:32] + 32'd4);
          end
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (imem_en) exp_q.push_back({imem_addr, mem_word(imem_addr)});
    end
  end

  // Move to just after the next rising edge, where inputs are driven.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse reset for one cycle and leave the first post-reset cycle current.
  task automatic restart(input logic ready);
    tick();
    reset = 1'b1;
    redirect = 1'b0;
    out_ready = ready;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    out_ready = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || imem_en !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got valid=%b en=%b, expected 0 0", out_valid, imem_en);
    end
    checks++;
    if (out_ins !== 32'h0 || out_pc !== 32'h0 || out_pcinc !== 32'h0) begin
      failures++;
      $display("FAIL reset_data: got ins=%h pc=%h pcinc=%h, expected zeros", out_ins, out_pc, out_pcinc);
    end
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (imem_en !== 1'b1 || imem_addr !== 32'(i * 4)) begin
        failures++;
        $display("FAIL first_addr%0d: got en=%b addr=%h, expected 1 %h", i, imem_en, imem_addr, 32'(i * 4));
      end
      checks++;
      if (out_valid !== (i == 2)) begin
        failures++;
        $display("FAIL first_latency%0d: got valid=%b, expected %b", i, out_valid, (i == 2));
      end
      if (i < 2) tick();
    end
    checks++;
    if (out_ins !== mem_word(0) || out_pc !== 32'h0 || out_pcinc !== 32'h4) begin
      failures++;
      $display("FAIL first_out: got ins=%h pc=%h pcinc=%h, expected %h 0 4", out_ins, out_pc, out_pcinc, mem_word(0));
    end
  endtask

  task automatic test_stream();
    logic [31:0] pc;
    pc = 32'h4;
    for (int i = 0; i < 12; i++) begin
      tick();
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_pc !== pc) begin
        failures++;
        $display("FAIL stream%0d: got valid=%b pc=%h, expected 1 %h", i, out_valid, out_pc, pc);
      end
      pc = pc + 32'd4;
    end
  endtask

  task automatic test_backpressure();
    bit found;
    restart(1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (imem_en !== (i < DEPTH)) begin
        failures++;
        $display("FAIL bp_en%0d: got en=%b, expected %b", i, imem_en, (i < DEPTH));
      end
      if (i >= 2) begin
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_ins !== mem_word(0)) begin
          failures++;
          $display("FAIL bp_head%0d: got valid=%b pc=%h ins=%h, expected 1 0 %h", i, out_valid, out_pc, out_ins, mem_word(0));
        end
      end
      tick();
    end
    checks++;
    if (dut.u_fifo.count !== 3'd4) begin
      failures++;
      $display("FAIL bp_count: got %0d, expected 4", dut.u_fifo.count);
    end
    out_ready = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k < 4) begin
        checks++;
        if (out_pc !== 32'(k * 4)) begin
          failures++;
          $display("FAIL bp_drain%0d: got pc=%h, expected %h", k, out_pc, 32'(k * 4));
        end
      end
      if (imem_en && !found) begin
        found = 1'b1;
        checks++;
        if (imem_addr !== 32'h10) begin
          failures++;
          $display("FAIL bp_resume: got addr=%h, expected 00000010", imem_addr);
        end
      end
      tick();
    end
    if (!found) begin
      checks++;
      failures++;
      $display("FAIL bp_resume: got no fetch within 12 cycles, expected addr 00000010");
    end
  endtask

  task automatic test_redirect_full();
    logic [31:0] pcs [4];
    pcs[0] = 32'h100; pcs[1] = 32'h104; pcs[2] = 32'h108; pcs[3] = 32'h10C;
    restart(1'b0);
    repeat (4) tick();
    redirect = 1'b1;
    redirect_pc = 32'h100;
    @(negedge clk);
    checks++;
    if (dut.u_fifo.count !== 3'd3 || dut.inflight !== 1'b1 || imem_en !== 1'b0) begin
      failures++;
      $display("FAIL rf_pre: got count=%0d inflight=%b en=%b, expected 3 1 0", dut.u_fifo.count, dut.inflight, imem_en);
    end
    tick();
    redirect = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || dut.u_fifo.count !== 3'd0) begin
      failures++;
      $display("FAIL rf_flush: got valid=%b count=%0d, expected 0 0", out_valid, dut.u_fifo.count);
    end
    checks++;
    if (imem_en !== 1'b1 || imem_addr !== 32'h100) begin
      failures++;
      $display("FAIL rf_refetch: got en=%b addr=%h, expected 1 00000100", imem_en, imem_addr);
    end
    tick();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rf_gap: got valid=%b, expected 0", out_valid);
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_pc !== pcs[k] || out_ins !== mem_word(pcs[k])) begin
        failures++;
        $display("FAIL rf_out%0d: got valid=%b pc=%h ins=%h, expected 1 %h %h", k, out_valid, out_pc, out_ins, pcs[k], mem_word(pcs[k]));
      end
    end
  endtask

  task automatic test_push_pop_wrap();
    int xfers;
    restart(1'b0);
    repeat (4) tick();
    out_ready = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if (dut.u_fifo.count !== 3'd3) begin
      failures++;
      $display("FAIL pp_count: got %0d after push+pop, expected 3", dut.u_fifo.count);
    end
    xfers = 0;
    for (int c = 0; c < 300 && xfers < 24; c++) begin
      tick();
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (out_valid && out_ready) xfers++;
    end
    checks++;
    if (xfers < 24) begin
      failures++;
      $display("FAIL pp_xfers: got %0d transfers in 300 cycles, expected 24", xfers);
    end
  endtask

  task automatic test_redirect_pop();
    bit seen;
    restart(1'b1);
    repeat (3) tick();
    redirect = 1'b1;
    redirect_pc = 32'h200;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL rp_pre: got valid=%b, expected 1", out_valid);
    end
    tick();
    redirect = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || dut.u_fifo.count !== 3'd0) begin
      failures++;
      $display("FAIL rp_flush: got valid=%b count=%0d, expected 0 0", out_valid, dut.u_fifo.count);
    end
    checks++;
    if (imem_en !== 1'b1 || imem_addr !== 32'h200) begin
      failures++;
      $display("FAIL rp_refetch: got en=%b addr=%h, expected 1 00000200", imem_en, imem_addr);
    end
    seen = 1'b0;
    for (int k = 0; k < 6 && !seen; k++) begin
      tick();
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        checks++;
        if (out_pc !== 32'h200 || k != 1) begin
          failures++;
          $display("FAIL rp_first: got pc=%h at cycle %0d, expected 00000200 at cycle 1", out_pc, k);
        end
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL rp_first: got no output within 6 cycles, expected pc 00000200");
    end
  endtask

  task automatic test_reset_mid();
    restart(1'b0);
    repeat (4) tick();
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (dut.u_fifo.count !== 3'd3 || dut.inflight !== 1'b1) begin
      failures++;
      $display("FAIL rm_pre: got count=%0d inflight=%b, expected 3 1", dut.u_fifo.count, dut.inflight);
    end
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_ins !== 32'h0 || out_pc !== 32'h0 || out_pcinc !== 32'h0 ||
        dut.u_fifo.count !== 3'd0) begin
      failures++;
      $display("FAIL rm_clear: got valid=%b ins=%h pc=%h pcinc=%h count=%0d, expected all 0",
               out_valid, out_ins, out_pc, out_pcinc, dut.u_fifo.count);
    end
    checks++;
    if (imem_en !== 1'b1 || imem_addr !== 32'h0) begin
      failures++;
      $display("FAIL rm_refetch: got en=%b addr=%h, expected 1 00000000", imem_en, imem_addr);
    end
    repeat (2) tick();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_ins !== mem_word(0)) begin
      failures++;
      $display("FAIL rm_first: got valid=%b pc=%h ins=%h, expected 1 0 %h", out_valid, out_pc, out_ins, mem_word(0));
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_full();
    test_push_pop_wrap();
    test_redirect_pop();
    test_reset_mid();
    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Time limit in case a scenario stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
